clk_div_monitor: RTL and testbench

//   Receive-side check for divided clocks made from clk_in (e.g. /2, /4, /8 outputs).

---
 rtl/clk_div_monitor_if.sv | 23 ++
 rtl/clk_div_monitor.sv | 151 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// Bundle between a divided-clock source (master) and clk_div_monitor (slave):
// the clock under test plus the monitor's measurement and status results.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clk_sig;
    logic             meas_valid;
    logic [CNT_W:0]   period_out;
    logic [CNT_W-1:0] high_out;
    logic             duty_ok;
    logic             locked;
    logic             stuck;

    modport master (
        output clk_sig,
        input  meas_valid, period_out, high_out, duty_ok, locked, stuck
    );

    modport slave (
        input  clk_sig,
        output meas_valid, period_out, high_out, duty_ok, locked, stuck
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock sampled in the clk_in domain and reports duty, lock and stuck.
// Define CLK_DIV_MON_SYNC_EN to add a 2-flop synchronizer ahead of the sample register.
module clk_div_monitor #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    clk_div_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               MW       = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_CNT = MW'(LOCK_N);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t           state_q, state_d;
    logic             sample_q, sample_dly_q;
    logic [CNT_W-1:0] cnt_hi_q, cnt_hi_d, cnt_lo_q, cnt_lo_d;
    logic [CNT_W:0]   period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             duty_q, duty_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             stuck_q, stuck_d;
    logic [MW-1:0]    match_q, match_d;
    logic             sig_in;
    logic             rise;
    logic             at_limit;
    logic [CNT_W:0]   meas_period;

`ifdef CLK_DIV_MON_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mon.clk_sig;
            sync2_q <= sync1_q;
        end
    end

    assign sig_in = sync2_q;
`else
    assign sig_in = mon.clk_sig;
`endif

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sample_q     <= 1'b0;
            sample_dly_q <= 1'b0;
        end else begin
            sample_q     <= sig_in;
            sample_dly_q <= sample_q;
        end
    end

    assign rise        = sample_q & ~sample_dly_q;
    assign meas_period = {1'b0, cnt_hi_q} + {1'b0, cnt_lo_q};
    // Only the counter of the phase currently being extended can run out of range.
    assign at_limit    = sample_q ? (cnt_hi_q == CNT_MAX) : (cnt_lo_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        cnt_lo_d     = cnt_lo_q;
        period_d     = period_q;
        high_d       = high_q;
        duty_d       = duty_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        stuck_d      = stuck_q;
        match_d      = match_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d  = MEAS;
                    cnt_hi_d = CNT_W'(1);
                    cnt_lo_d = '0;
                    stuck_d  = 1'b0;
                end
            end
            MEAS: begin
                if (rise) begin
                    period_d     = meas_period;
                    high_d       = cnt_hi_q;
                    duty_d       = ({cnt_hi_q, 1'b0} == meas_period);
                    meas_valid_d = 1'b1;
                    cnt_hi_d     = CNT_W'(1);
                    cnt_lo_d     = '0;
                    stuck_d      = 1'b0;
                    // match_q == 0 marks the first measurement since reset or timeout.
                    if (match_q == '0) begin
                        match_d = MW'(1);
                    end else if ((meas_period == period_q) && (cnt_hi_q == high_q)) begin
                        match_d = (match_q == LOCK_CNT) ? LOCK_CNT : match_q + MW'(1);
                    end else begin
                        match_d = MW'(1);
                    end
                    locked_d = (match_d == LOCK_CNT);
                end else if (at_limit) begin
                    state_d  = IDLE;
                    stuck_d  = 1'b1;
                    locked_d = 1'b0;
                    match_d  = '0;
                end else if (sample_q) begin
                    cnt_hi_d = cnt_hi_q + CNT_W'(1);
                end else begin
                    cnt_lo_d = cnt_lo_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_hi_q     <= '0;
            cnt_lo_q     <= '0;
            period_q     <= '0;
            high_q       <= '0;
            duty_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            stuck_q      <= 1'b0;
            match_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            cnt_lo_q     <= cnt_lo_d;
            period_q     <= period_d;
            high_q       <= high_d;
            duty_q       <= duty_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            stuck_q      <= stuck_d;
            match_q      <= match_d;
        end
    end

    assign mon.meas_valid = meas_valid_q;
    assign mon.period_out = period_q;
    assign mon.high_out   = high_q;
    assign mon.duty_ok    = duty_q;
    assign mon.locked     = locked_q;
    assign mon.stuck      = stuck_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed and random phase patterns on clk_sig compared cycle by cycle
// against a timestamp-based reference model of the measurement, lock and timeout rules.
module tb_clk_div_monitor;
    localparam int CNT_W  = 8;
    localparam int LOCK_N = 4;
    localparam int LIMIT  = (1 << CNT_W) - 1;
`ifdef CLK_DIV_MON_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        bit mv;
        int period;
        int high;
        bit duty;
        bit locked;
        bit stuck;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clk_div_monitor_if #(.CNT_W(CNT_W)) ifc();

    clk_div_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk_in (clk),
        .rst    (rst),
        .mon    (ifc)
    );

    always #5 clk = ~clk;

    int   vectorCount = 0;
    int   missCount   = 0;
    exp_t expQ[$];
    exp_t modelOut;
    int   t, riseAt, fallAt, phaseStart, lastPer, lastHi, runCount;
    bit   prevS, armed;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Reference model works on edge timestamps: a measurement spans rise to rise,
    // high time spans rise to fall, and a phase lasting more than LIMIT samples times out.
    function automatic void modelReset();
        t = 0; riseAt = 0; fallAt = 0; phaseStart = 0;
        lastPer = 0; lastHi = 0; runCount = 0;
        prevS = 1'b0; armed = 1'b0;
        modelOut = '{mv: 1'b0, period: 0, high: 0, duty: 1'b0, locked: 1'b0, stuck: 1'b0};
        expQ.delete();
        repeat (LAT) expQ.push_back(modelOut);
    endfunction

    function automatic void modelStep(input bit s);
        int per, hi;
        modelOut.mv = 1'b0;
        if (s && !prevS) begin
            modelOut.stuck = 1'b0;
            if (armed) begin
                per = t - riseAt;
                hi  = fallAt - riseAt;
                if (runCount > 0 && per == lastPer && hi == lastHi) runCount++;
                else runCount = 1;
                lastPer = per;
                lastHi  = hi;
                modelOut.mv     = 1'b1;
                modelOut.period = per;
                modelOut.high   = hi;
                modelOut.duty   = (2 * hi == per);
                modelOut.locked = (runCount >= LOCK_N);
            end
            armed      = 1'b1;
            riseAt     = t;
            phaseStart = t;
        end else if (!s && prevS) begin
            fallAt     = t;
            phaseStart = t;
        end else if (armed && (t - phaseStart) == LIMIT) begin
            modelOut.stuck  = 1'b1;
            modelOut.locked = 1'b0;
            armed           = 1'b0;
            runCount        = 0;
        end
        prevS = s;
        t++;
    endfunction

    task automatic applyStimulus(input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("meas_valid", int'(ifc.meas_valid), int'(e.mv));
        checkOutput("period_out", int'(ifc.period_out), e.period);
        checkOutput("high_out",   int'(ifc.high_out),   e.high);
        checkOutput("duty_ok",    int'(ifc.duty_ok),    int'(e.duty));
        checkOutput("locked",     int'(ifc.locked),     int'(e.locked));
        checkOutput("stuck",      int'(ifc.stuck),      int'(e.stuck));
        ifc.clk_sig = v;
        modelStep(v);
        expQ.push_back(modelOut);
    endtask

    task automatic driveLevel(input bit v, input int n);
        for (int i = 0; i < n; i++) applyStimulus(v);
    endtask

    task automatic drivePhases(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            driveLevel(1'b1, hi);
            driveLevel(1'b0, lo);
        end
    endtask

    // Async reset must clear every output without waiting for a clock edge.
    task automatic resetDut();
        rst = 1'b0;
        ifc.clk_sig = 1'b0;
        #1;
        checkOutput("rst_meas_valid", int'(ifc.meas_valid), 0);
        checkOutput("rst_period_out", int'(ifc.period_out), 0);
        checkOutput("rst_high_out",   int'(ifc.high_out),   0);
        checkOutput("rst_duty_ok",    int'(ifc.duty_ok),    0);
        checkOutput("rst_locked",     int'(ifc.locked),     0);
        checkOutput("rst_stuck",      int'(ifc.stuck),      0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
    endtask

    initial begin
        ifc.clk_sig = 1'b0;
        #2;
        resetDut();

        $display("[TB] divide-by-2");
        drivePhases(1, 1, 8);

        $display("[TB] divide-by-8 then divide-by-4");
        drivePhases(4, 4, 6);
        drivePhases(2, 2, 6);

        $display("[TB] 3 high / 5 low");
        drivePhases(3, 5, 6);

        $display("[TB] stuck low after lock, then restart");
        drivePhases(1, 1, 6);
        driveLevel(1'b0, 300);
        drivePhases(1, 1, 6);

        $display("[TB] reset mid-high while locked");
        drivePhases(4, 4, 6);
        driveLevel(1'b1, 2);
        resetDut();
        drivePhases(4, 4, 6);

        $display("[TB] phase limits");
        drivePhases(1, 1, 3);
        drivePhases(255, 1, 3);
        drivePhases(256, 4, 1);
        drivePhases(3, 3, 3);
        drivePhases(2, 255, 2);
        drivePhases(2, 256, 1);
        drivePhases(2, 2, 3);

        $display("[TB] random patterns");
        for (int k = 0; k < 40; k++) begin
            drivePhases($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(6, 1));
        end
        for (int k = 0; k < 4; k++) begin
            drivePhases($urandom_range(258, 250), $urandom_range(3, 1), $urandom_range(2, 1));
            drivePhases($urandom_range(3, 1), $urandom_range(258, 250), 1);
        end
        drivePhases(1, 1, 6);
        driveLevel(1'b0, LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
